// File: rtl/draw_image_revers_if.sv
// Purpose : Bundles the VGA timing, background pixel, sprite position and
//           sprite-ROM signals that pass between a video source and the
//           draw_image_revers sprite overlay stage.
// Signals : hcount_in/vcount_in, hsync_in/vsync_in, hblnk_in/vblnk_in, rgb_in
//             incoming VGA beam position, timing and background pixel
//           xpos/ypos, revers_en
//             sprite top-left corner and horizontal-mirror enable
//           rom_addr / rom_rgb
//             sprite ROM address (from the overlay) and ROM data (to it)
//           hcount_out/vcount_out, hsync_out/vsync_out, hblnk_out/vblnk_out,
//           rgb_out
//             delayed timing and composited pixel
// Modports: master - the side that drives the video stream and the ROM data
//           slave  - the overlay stage itself
interface draw_image_revers_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        revers_en;
  logic [13:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, xpos, ypos, revers_en, rom_rgb,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, xpos, ypos, revers_en, rom_rgb,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/draw_image_revers.sv
// Purpose : Overlays a (optionally horizontally mirrored) sprite read from an
//           external synchronous ROM onto a VGA pixel stream. Pixels whose ROM
//           colour equals KEY_RGB are transparent and show the background.
//           Three-stage pipeline: address generation, ROM wait, compositing.
// Ports   : clk   - single clock
//           rst_n - asynchronous active-low reset, clears every register
//           bus   - draw_image_revers_if.slave (timing in/out, background
//                   pixel, sprite position, ROM address/data, output pixel)
// Params  : IMG_W   - sprite width in pixels (power of two, 128 max)
//           IMG_H   - sprite height in pixels (128 max)
//           KEY_RGB - transparent colour key
module draw_image_revers #(
  parameter int          IMG_W   = 128,
  parameter int          IMG_H   = 128,
  parameter logic [11:0] KEY_RGB = 12'h0F0
) (
  input logic              clk,
  input logic              rst_n,
  draw_image_revers_if.slave bus
);

  localparam logic [12:0] IMG_W13  = 13'(IMG_W);
  localparam logic [12:0] IMG_H13  = 13'(IMG_H);
  localparam logic [6:0]  IMG_W_M1 = 7'(IMG_W - 1);

  // Frame-latched sprite placement
  logic [11:0] r_xposL;
  logic [11:0] r_yposL;
  logic        r_reversL;

  // Stage 1 registers
  logic        r_s1Inside;
  logic [10:0] r_s1Hcount;
  logic [10:0] r_s1Vcount;
  logic        r_s1Hsync;
  logic        r_s1Vsync;
  logic        r_s1Hblnk;
  logic        r_s1Vblnk;
  logic [11:0] r_s1Rgb;
  logic [13:0] r_romAddr;

  // Stage 2 registers
  logic        r_s2Inside;
  logic [10:0] r_s2Hcount;
  logic [10:0] r_s2Vcount;
  logic        r_s2Hsync;
  logic        r_s2Vsync;
  logic        r_s2Hblnk;
  logic        r_s2Vblnk;
  logic [11:0] r_s2Rgb;

  // Stage 3 (output) registers
  logic [10:0] r_hcountOut;
  logic [10:0] r_vcountOut;
  logic        r_hsyncOut;
  logic        r_vsyncOut;
  logic        r_hblnkOut;
  logic        r_vblnkOut;
  logic [11:0] r_rgbOut;

  logic        w_frameStart;
  logic [12:0] w_hcount13;
  logic [12:0] w_vcount13;
  logic [12:0] w_xEnd;
  logic [12:0] w_yEnd;
  logic        w_inside;
  logic [6:0]  w_relX;
  logic [6:0]  w_relY;
  logic [6:0]  w_imgX;
  logic [13:0] w_romAddr;

  assign w_frameStart = (bus.hcount_in == 11'd0) && (bus.vcount_in == 11'd0);

  // Bounds are compared 13 bits wide so a sprite placed near 4095 cannot
  // wrap its right/bottom edge back to a small coordinate.
  assign w_hcount13 = {2'b00, bus.hcount_in};
  assign w_vcount13 = {2'b00, bus.vcount_in};
  assign w_xEnd     = {1'b0, r_xposL} + IMG_W13;
  assign w_yEnd     = {1'b0, r_yposL} + IMG_H13;

  assign w_inside = (w_hcount13 >= {1'b0, r_xposL}) && (w_hcount13 < w_xEnd) &&
                    (w_vcount13 >= {1'b0, r_yposL}) && (w_vcount13 < w_yEnd) &&
                    !bus.hblnk_in && !bus.vblnk_in;

  // Only the low 7 bits of the relative position reach the ROM address, and
  // modular subtraction gives the same low bits as the full 12-bit difference.
  assign w_relX    = bus.hcount_in[6:0] - r_xposL[6:0];
  assign w_relY    = bus.vcount_in[6:0] - r_yposL[6:0];
  assign w_imgX    = r_reversL ? (IMG_W_M1 - w_relX) : w_relX;
  assign w_romAddr = w_inside ? {w_relY, w_imgX} : 14'h0000;

  // Sprite placement is sampled only on the first pixel of a frame so the
  // sprite never tears when the controller moves it mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xposL   <= '0;
      r_yposL   <= '0;
      r_reversL <= 1'b0;
    end else if (w_frameStart) begin
      r_xposL   <= bus.xpos;
      r_yposL   <= bus.ypos;
      r_reversL <= bus.revers_en;
    end
  end

  // Stage 1: issue the ROM address and carry timing/background along with
  // the inside flag for the pixel being addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Inside <= 1'b0;
      r_s1Hcount <= '0;
      r_s1Vcount <= '0;
      r_s1Hsync  <= 1'b0;
      r_s1Vsync  <= 1'b0;
      r_s1Hblnk  <= 1'b0;
      r_s1Vblnk  <= 1'b0;
      r_s1Rgb    <= '0;
      r_romAddr  <= '0;
    end else begin
      r_s1Inside <= w_inside;
      r_s1Hcount <= bus.hcount_in;
      r_s1Vcount <= bus.vcount_in;
      r_s1Hsync  <= bus.hsync_in;
      r_s1Vsync  <= bus.vsync_in;
      r_s1Hblnk  <= bus.hblnk_in;
      r_s1Vblnk  <= bus.vblnk_in;
      r_s1Rgb    <= bus.rgb_in;
      r_romAddr  <= w_romAddr;
    end
  end

  // Stage 2: wait one cycle while the synchronous ROM produces its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Inside <= 1'b0;
      r_s2Hcount <= '0;
      r_s2Vcount <= '0;
      r_s2Hsync  <= 1'b0;
      r_s2Vsync  <= 1'b0;
      r_s2Hblnk  <= 1'b0;
      r_s2Vblnk  <= 1'b0;
      r_s2Rgb    <= '0;
    end else begin
      r_s2Inside <= r_s1Inside;
      r_s2Hcount <= r_s1Hcount;
      r_s2Vcount <= r_s1Vcount;
      r_s2Hsync  <= r_s1Hsync;
      r_s2Vsync  <= r_s1Vsync;
      r_s2Hblnk  <= r_s1Hblnk;
      r_s2Vblnk  <= r_s1Vblnk;
      r_s2Rgb    <= r_s1Rgb;
    end
  end

  // Stage 3: composite. Blanking forces black; otherwise an opaque sprite
  // pixel wins over the background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcountOut <= '0;
      r_vcountOut <= '0;
      r_hsyncOut  <= 1'b0;
      r_vsyncOut  <= 1'b0;
      r_hblnkOut  <= 1'b0;
      r_vblnkOut  <= 1'b0;
      r_rgbOut    <= '0;
    end else begin
      r_hcountOut <= r_s2Hcount;
      r_vcountOut <= r_s2Vcount;
      r_hsyncOut  <= r_s2Hsync;
      r_vsyncOut  <= r_s2Vsync;
      r_hblnkOut  <= r_s2Hblnk;
      r_vblnkOut  <= r_s2Vblnk;
      if (r_s2Hblnk || r_s2Vblnk) begin
        r_rgbOut <= 12'h000;
      end else if (r_s2Inside && (bus.rom_rgb != KEY_RGB)) begin
        r_rgbOut <= bus.rom_rgb;
      end else begin
        r_rgbOut <= r_s2Rgb;
      end
    end
  end

  assign bus.rom_addr   = r_romAddr;
  assign bus.hcount_out = r_hcountOut;
  assign bus.vcount_out = r_vcountOut;
  assign bus.hsync_out  = r_hsyncOut;
  assign bus.vsync_out  = r_vsyncOut;
  assign bus.hblnk_out  = r_hblnkOut;
  assign bus.vblnk_out  = r_vblnkOut;
  assign bus.rgb_out    = r_rgbOut;

endmodule

// File: tb/tb_draw_image_revers.sv
// Purpose : Self-checking bench for draw_image_revers. A synchronous sprite
//           ROM is modelled here; expected outputs come from an integer-level
//           model of the sprite placement rules (frame-latched position,
//           bounds, mirroring, colour key, blanking, 3-cycle latency).
module tb_draw_image_revers;

  localparam int          IMG_W = 128;
  localparam int          IMG_H = 128;
  localparam logic [11:0] KEY   = 12'h0F0;

  logic clk;
  logic rst_n;

  draw_image_revers_if busIf();

  draw_image_revers #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .KEY_RGB(KEY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM content: every address whose low nibble is 5 is transparent.
  function automatic logic [11:0] romData(input logic [13:0] a);
    if (a[3:0] == 4'h5) return KEY;
    return 12'(a * 7 + 13) ^ 12'hA5A;
  endfunction

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk) busIf.rom_rgb <= romData(busIf.rom_addr);

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } expT;

  typedef struct {
    int          h;
    int          v;
    int          x;
    int          y;
    logic        rev;
    logic        hb;
    logic        vb;
    logic [13:0] expAddr;
  } vecT;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: placement seen by the sprite, and in-flight expectations.
  int   latchX;
  int   latchY;
  logic latchRev;
  expT  expQ[$];

  int   curX;
  int   curY;
  logic curRev;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    expT z;
    z = '{h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0};
    latchX   = 0;
    latchY   = 0;
    latchRev = 1'b0;
    expQ.delete();
    expQ.push_back(z);
    expQ.push_back(z);
  endtask

  // Drive one pixel (called just after a clock edge), predict its outputs,
  // advance one clock and compare.
  task automatic applyStimulus(input int h, input int v, input logic hb, input logic vb);
    expT         e;
    expT         old;
    logic [11:0] bg;
    logic [13:0] expAddr;
    logic [11:0] sprite;
    int          relX;
    int          imgX;
    bit          ins;

    bg = 12'($urandom);
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.hs  = 1'($urandom);
    e.vs  = 1'($urandom);
    e.hb  = hb;
    e.vb  = vb;

    busIf.hcount_in = e.h;
    busIf.vcount_in = e.v;
    busIf.hsync_in  = e.hs;
    busIf.vsync_in  = e.vs;
    busIf.hblnk_in  = hb;
    busIf.vblnk_in  = vb;
    busIf.rgb_in    = bg;
    busIf.xpos      = 12'(curX);
    busIf.ypos      = 12'(curY);
    busIf.revers_en = curRev;

    ins = (h >= latchX) && (h < latchX + IMG_W) &&
          (v >= latchY) && (v < latchY + IMG_H) && !hb && !vb;
    relX = h - latchX;
    imgX = latchRev ? (IMG_W - 1 - relX) : relX;
    expAddr = ins ? 14'(((v - latchY) % 128) * 128 + (imgX % 128)) : 14'h0000;
    sprite  = romData(expAddr);
    if (hb || vb)                e.rgb = 12'h000;
    else if (ins && sprite != KEY) e.rgb = sprite;
    else                         e.rgb = bg;
    expQ.push_back(e);

    if (h == 0 && v == 0) begin
      latchX   = curX;
      latchY   = curY;
      latchRev = curRev;
    end

    @(posedge clk);
    #1;
    checkOutput("rom_addr", 16'(busIf.rom_addr), 16'(expAddr));
    if (expQ.size() == 3) begin
      old = expQ.pop_front();
      checkOutput("rgb_out",    16'(busIf.rgb_out),    16'(old.rgb));
      checkOutput("hcount_out", 16'(busIf.hcount_out), 16'(old.h));
      checkOutput("vcount_out", 16'(busIf.vcount_out), 16'(old.v));
      checkOutput("sync/blank",
                  16'({busIf.hsync_out, busIf.vsync_out, busIf.hblnk_out, busIf.vblnk_out}),
                  16'({old.hs, old.vs, old.hb, old.vb}));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rom_addr"},   16'(busIf.rom_addr),   16'h0);
    checkOutput({tag, " rgb_out"},    16'(busIf.rgb_out),    16'h0);
    checkOutput({tag, " hcount_out"}, 16'(busIf.hcount_out), 16'h0);
    checkOutput({tag, " vcount_out"}, 16'(busIf.vcount_out), 16'h0);
    checkOutput({tag, " sync/blank"},
                16'({busIf.hsync_out, busIf.vsync_out, busIf.hblnk_out, busIf.vblnk_out}), 16'h0);
  endtask

  vecT tbl[$];

  initial begin
    tbl.push_back('{h: 0,    v: 0,   x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 100,  v: 50,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 101,  v: 50,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0001});
    tbl.push_back('{h: 100,  v: 51,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0080});
    tbl.push_back('{h: 227,  v: 50,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h007F});
    tbl.push_back('{h: 228,  v: 50,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 99,   v: 50,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 100,  v: 49,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 100,  v: 177, x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h3F80});
    tbl.push_back('{h: 100,  v: 178, x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 150,  v: 60,  x: 100,  y: 50, rev: 0, hb: 1, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 150,  v: 60,  x: 100,  y: 50, rev: 0, hb: 0, vb: 1, expAddr: 14'h0000});
    tbl.push_back('{h: 105,  v: 50,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0005});
    tbl.push_back('{h: 0,    v: 0,   x: 100,  y: 50, rev: 1, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 100,  v: 50,  x: 100,  y: 50, rev: 1, hb: 0, vb: 0, expAddr: 14'h007F});
    tbl.push_back('{h: 227,  v: 50,  x: 100,  y: 50, rev: 1, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 101,  v: 51,  x: 100,  y: 50, rev: 1, hb: 0, vb: 0, expAddr: 14'h00FE});
    tbl.push_back('{h: 0,    v: 0,   x: 1000, y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 1000, v: 50,  x: 1000, y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 1023, v: 50,  x: 1000, y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0017});
    tbl.push_back('{h: 0,    v: 51,  x: 1000, y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 104,  v: 51,  x: 1000, y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 0,    v: 0,   x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 120,  v: 60,  x: 100,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0514});
    tbl.push_back('{h: 120,  v: 61,  x: 300,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0594});
    tbl.push_back('{h: 300,  v: 61,  x: 300,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 0,    v: 0,   x: 300,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});
    tbl.push_back('{h: 300,  v: 61,  x: 300,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0580});
    tbl.push_back('{h: 120,  v: 61,  x: 300,  y: 50, rev: 0, hb: 0, vb: 0, expAddr: 14'h0000});

    rst_n = 1'b0;
    busIf.hcount_in = '0;
    busIf.vcount_in = '0;
    busIf.hsync_in  = 1'b0;
    busIf.vsync_in  = 1'b0;
    busIf.hblnk_in  = 1'b0;
    busIf.vblnk_in  = 1'b0;
    busIf.rgb_in    = '0;
    busIf.xpos      = '0;
    busIf.ypos      = '0;
    busIf.revers_en = 1'b0;
    curX = 0;
    curY = 0;
    curRev = 1'b0;

    #1;
    checkAllZero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();

    $display("[TB] directed vectors");
    foreach (tbl[i]) begin
      curX   = tbl[i].x;
      curY   = tbl[i].y;
      curRev = tbl[i].rev;
      applyStimulus(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb);
      checkOutput($sformatf("table[%0d] rom_addr", i), 16'(busIf.rom_addr), 16'(tbl[i].expAddr));
    end

    $display("[TB] random frames");
    for (int f = 0; f < 30; f++) begin
      curX   = $urandom_range(0, 1100);
      curY   = $urandom_range(0, 700);
      curRev = 1'($urandom);
      applyStimulus(0, 0, 1'b0, 1'b0);
      for (int p = 0; p < 40; p++) begin
        int h;
        int v;
        if (p == 20 && $urandom_range(0, 1) == 1) curX = $urandom_range(0, 1100);
        h = latchX + $urandom_range(0, IMG_W + 20) - 10;
        v = latchY + $urandom_range(0, IMG_H + 20) - 10;
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        applyStimulus(h, v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      end
    end

    $display("[TB] mid-line reset");
    curX = 200;
    curY = 100;
    curRev = 1'b0;
    applyStimulus(0, 0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) applyStimulus(210 + p, 110, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();

    curX = 500;
    curY = 300;
    applyStimulus(10, 10, 1'b0, 1'b0);
    checkOutput("post-reset latch addr", 16'(busIf.rom_addr), 16'h050A);
    applyStimulus(500, 300, 1'b0, 1'b0);
    checkOutput("post-reset old pos addr", 16'(busIf.rom_addr), 16'h0000);
    for (int p = 0; p < 4; p++) applyStimulus(5 + p, 20, 1'b0, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0);
    applyStimulus(500, 300, 1'b0, 1'b0);
    checkOutput("new frame addr", 16'(busIf.rom_addr), 16'h0000);
    applyStimulus(501, 301, 1'b0, 1'b0);
    checkOutput("new frame addr+1", 16'(busIf.rom_addr), 16'h0081);
    for (int p = 0; p < 3; p++) applyStimulus(520 + p, 310, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/draw_image_revers.md
DRAW_IMAGE_REVERS -- requirements
Module: draw_image_revers

Interface
REQ-001 The module SHALL have parameter IMG_W, default 128, meaning sprite width in pixels (power of two, 128 max).
REQ-002 The module SHALL have parameter IMG_H, default 128, meaning sprite height in pixels (128 max).
REQ-003 The module SHALL have parameter KEY_RGB, default 12'h0F0, meaning transparent colour key.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have ports hcount_in and vcount_in, input, 11 bits each: VGA beam position.
REQ-007 The module SHALL have ports hsync_in, vsync_in, hblnk_in and vblnk_in, input, 1 bit each: VGA timing.
REQ-008 The module SHALL have port rgb_in, input, 12 bits: background pixel.
REQ-009 The module SHALL have ports xpos and ypos, input, 12 bits each: sprite top-left corner.
REQ-010 The module SHALL have port revers_en, input, 1 bit: 1 = mirror sprite horizontally.
REQ-011 The module SHALL have port rom_addr, output, 14 bits: {rel_y[6:0], img_x[6:0]} to the sprite ROM.
REQ-012 The module SHALL have port rom_rgb, input, 12 bits: ROM data, valid 1 cycle after rom_addr.
REQ-013 The module SHALL have ports hcount_out and vcount_out, output, 11 bits each: timing, delayed.
REQ-014 The module SHALL have ports hsync_out, vsync_out, hblnk_out and vblnk_out, output, 1 bit each: timing, delayed.
REQ-015 The module SHALL have port rgb_out, output, 12 bits: composited pixel.

Function
REQ-016 xpos, ypos and revers_en SHALL be captured into internal registers only on the cycle where hcount_in==0 and vcount_in==0, so they are held constant for the whole frame.
REQ-017 Stage 1 (edge N+1) SHALL register the following:
- rel_x = hcount_in - xpos_l and rel_y = vcount_in - ypos_l, each 12-bit;
- inside flag;
- rom_addr;
- all timing and rgb_in.
REQ-018 inside SHALL be 1 when all of the following hold:
- hcount_in >= xpos_l and hcount_in < xpos_l+IMG_W;
- vcount_in >= ypos_l and vcount_in < ypos_l+IMG_H;
- hblnk_in==0 and vblnk_in==0.
The upper-bound sums SHALL be computed 13 bits wide so that no wrap-around occurs near 4095.
REQ-019 img_x SHALL be IMG_W-1-rel_x when revers_en_l==1, else rel_x, truncated to 7 bits; rom_addr SHALL be {rel_y[6:0], img_x[6:0]} when inside, else 14'h0.
REQ-020 Stage 2 (edge N+2) SHALL delay the timing signals, rgb_in and inside by one further cycle to align with rom_rgb.
REQ-021 Stage 3 (edge N+3) SHALL register the outputs: rgb_out = rom_rgb when the stage-2 inside==1 and rom_rgb!=KEY_RGB, else the delayed rgb_in.
REQ-022 Total latency from any input to the corresponding output SHALL be exactly 3 clk cycles for every output except rom_addr, whose latency is 1.
REQ-023 rgb_out SHALL be 12'h000 whenever the delayed hblnk or vblnk is 1.
REQ-024 A sprite partly off-screen (xpos+IMG_W > 1023) SHALL draw only its visible pixels, with no wrapped columns at the left edge.
REQ-025 A change of xpos, ypos or revers_en mid-frame SHALL take effect at the next frame start only.

Reset
REQ-026 While rst_n==0, the following SHALL be 0, asynchronously:
- all outputs, including rom_addr;
- all pipeline registers;
- xpos_l, ypos_l and revers_en_l.
REQ-027 After rst_n is released, the first valid output SHALL appear 3 cycles after the first input sample; a reset mid-frame SHALL discard the pipeline contents.

Verification
REQ-028 Set xpos=100, ypos=50, revers_en=0, and drive a frame; at hcount=100, vcount=50 -> rom_addr=14'h0000 one cycle later, and rgb_out=rom_rgb three cycles later.
REQ-029 Keep xpos=100, ypos=50 and set revers_en=1; at hcount=100, vcount=50 -> rom_addr=14'h007F; at hcount=227 -> 14'h0000.
REQ-030 Make rom_rgb equal KEY_RGB (12'h0F0) inside the sprite -> rgb_out equals the rgb_in driven 3 cycles earlier.
REQ-031 Set xpos=1000 at frame start -> the sprite is drawn for hcount 1000..1023 only; hcount 0..104 of the next line shows background.
REQ-032 Change xpos from 100 to 300 at vcount=200 -> the rest of that frame still draws at 100, and the next frame draws at 300.
REQ-033 Assert rst_n=0 mid-line for 2 cycles -> all outputs become 0 immediately, without waiting for a clk edge, and xpos_l=0 until the next frame start.
